// File: rtl/decode_issue.sv
// decode_issue: RV32I decode/issue stage between fetch and execute.
//
// Decodes the incoming instruction into source/destination register usage, drives the register
// file read addresses, tracks in-flight destination registers in a 31-entry scoreboard, stalls
// fetch on RAW hazards and presents one issue slot to execute over a valid/ready handshake.
// Hazard-free throughput is one instruction per cycle.
//
// Optional feature macro: WB_BYPASS_EN
//   Defined:   a source whose only hazard is a pending bit being cleared by writeback in the same
//              cycle issues immediately; the writeback data is captured and forwarded as operand.
//   Undefined: the writeback clear is visible one cycle later; wb_data_ip is unused.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   instr_ip/instr_valid_ip   instruction from fetch; instr_ready_op back-pressures fetch
//   rd_addr1_op/rd_addr2_op   register file read addresses
//   rd_data1_ip/rd_data2_ip   register file read data (1-cycle latency)
//   ex_valid_op/ex_ready_ip   issue handshake to execute
//   ex_instr_op, ex_rd_op     issued instruction word and destination (0 if none)
//   ex_rs1/2_data_op          issued operands
//   wb_valid_ip/wb_addr_ip    writeback retiring a register write; wb_data_ip its data
//   flush_ip                  drops the issue slot (branch redirect)
//   sb_pending_op             scoreboard bitmap, bit 0 always 0

module decode_issue #(
  parameter int unsigned XW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [31:0]   instr_ip,
  input  logic          instr_valid_ip,
  output logic          instr_ready_op,
  output logic [4:0]    rd_addr1_op,
  output logic [4:0]    rd_addr2_op,
  input  logic [XW-1:0] rd_data1_ip,
  input  logic [XW-1:0] rd_data2_ip,
  output logic          ex_valid_op,
  input  logic          ex_ready_ip,
  output logic [31:0]   ex_instr_op,
  output logic [4:0]    ex_rd_op,
  output logic [XW-1:0] ex_rs1_data_op,
  output logic [XW-1:0] ex_rs2_data_op,
  input  logic          wb_valid_ip,
  input  logic [4:0]    wb_addr_ip,
  input  logic [XW-1:0] wb_data_ip,
  input  logic          flush_ip,
  output logic [31:0]   sb_pending_op
);

  // Decode
  logic       use_rs1, use_rs2, writes_rd;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;

  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    case (instr_ip[6:0])
      7'b0110011: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        writes_rd = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: begin
        use_rs1   = 1'b1;
        writes_rd = 1'b1;
      end
      7'b0100011, 7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0110111, 7'b0010111, 7'b1101111: begin
        writes_rd = 1'b1;
      end
      default: ;
    endcase
  end

  assign dec_rs1 = use_rs1   ? instr_ip[19:15] : 5'd0;
  assign dec_rs2 = use_rs2   ? instr_ip[24:20] : 5'd0;
  assign dec_rd  = writes_rd ? instr_ip[11:7]  : 5'd0;

  // State
  logic          slot_valid_q, slot_valid_d;
  logic [31:0]   slot_instr_q, slot_instr_d;
  logic [4:0]    slot_rd_q, slot_rd_d;
  logic [4:0]    slot_rs1_q, slot_rs1_d;
  logic [4:0]    slot_rs2_q, slot_rs2_d;
  logic [31:0]   pending_q, pending_d;

  // Hazard detection; the slot's rd is not yet in pending_q, so it is compared separately.
  logic slot_hit1, slot_hit2, pend_hit1, pend_hit2, haz1, haz2;
  logic accept, ex_fire;

  assign slot_hit1 = slot_valid_q && (slot_rd_q == dec_rs1);
  assign slot_hit2 = slot_valid_q && (slot_rd_q == dec_rs2);
  assign pend_hit1 = pending_q[dec_rs1];
  assign pend_hit2 = pending_q[dec_rs2];

`ifdef WB_BYPASS_EN
  logic          wb_hit1, wb_hit2;
  logic          byp1_vld_q, byp1_vld_d, byp2_vld_q, byp2_vld_d;
  logic [XW-1:0] byp1_q, byp1_d, byp2_q, byp2_d;

  assign wb_hit1 = wb_valid_ip && (wb_addr_ip == dec_rs1);
  assign wb_hit2 = wb_valid_ip && (wb_addr_ip == dec_rs2);
  assign haz1    = (dec_rs1 != 5'd0) && (slot_hit1 || (pend_hit1 && !wb_hit1));
  assign haz2    = (dec_rs2 != 5'd0) && (slot_hit2 || (pend_hit2 && !wb_hit2));
`else
  // Register file has no write-to-read bypass, so a same-cycle clear must still stall.
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data_ip;
  assign haz1 = (dec_rs1 != 5'd0) && (slot_hit1 || pend_hit1);
  assign haz2 = (dec_rs2 != 5'd0) && (slot_hit2 || pend_hit2);
`endif

  assign ex_fire        = slot_valid_q && ex_ready_ip;
  assign instr_ready_op = !flush_ip && (!slot_valid_q || ex_ready_ip) && !haz1 && !haz2;
  assign accept         = instr_valid_ip && instr_ready_op;

  // Next state
  always_comb begin
    slot_valid_d = slot_valid_q;
    slot_instr_d = slot_instr_q;
    slot_rd_d    = slot_rd_q;
    slot_rs1_d   = slot_rs1_q;
    slot_rs2_d   = slot_rs2_q;
    pending_d    = pending_q;

    if (flush_ip) begin
      slot_valid_d = 1'b0;
    end else if (accept) begin
      slot_valid_d = 1'b1;
      slot_instr_d = instr_ip;
      slot_rd_d    = dec_rd;
      slot_rs1_d   = dec_rs1;
      slot_rs2_d   = dec_rs2;
    end else if (ex_fire) begin
      slot_valid_d = 1'b0;
    end

    // Clear first so a same-register set in the same cycle wins.
    if (wb_valid_ip && (wb_addr_ip != 5'd0)) pending_d[wb_addr_ip] = 1'b0;
    if (ex_fire && (slot_rd_q != 5'd0))      pending_d[slot_rd_q]  = 1'b1;
    pending_d[0] = 1'b0;
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    byp1_vld_d = byp1_vld_q;
    byp2_vld_d = byp2_vld_q;
    byp1_d     = byp1_q;
    byp2_d     = byp2_q;
    if (accept) begin
      byp1_vld_d = (dec_rs1 != 5'd0) && pend_hit1 && wb_hit1;
      byp2_vld_d = (dec_rs2 != 5'd0) && pend_hit2 && wb_hit2;
      byp1_d     = wb_data_ip;
      byp2_d     = wb_data_ip;
    end else if (flush_ip || ex_fire) begin
      byp1_vld_d = 1'b0;
      byp2_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byp1_vld_q <= 1'b0;
      byp2_vld_q <= 1'b0;
      byp1_q     <= '0;
      byp2_q     <= '0;
    end else begin
      byp1_vld_q <= byp1_vld_d;
      byp2_vld_q <= byp2_vld_d;
      byp1_q     <= byp1_d;
      byp2_q     <= byp2_d;
    end
  end

  assign ex_rs1_data_op = byp1_vld_q ? byp1_q : rd_data1_ip;
  assign ex_rs2_data_op = byp2_vld_q ? byp2_q : rd_data2_ip;
`else
  assign ex_rs1_data_op = rd_data1_ip;
  assign ex_rs2_data_op = rd_data2_ip;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_valid_q <= 1'b0;
      slot_instr_q <= '0;
      slot_rd_q    <= '0;
      slot_rs1_q   <= '0;
      slot_rs2_q   <= '0;
      pending_q    <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_instr_q <= slot_instr_d;
      slot_rd_q    <= slot_rd_d;
      slot_rs1_q   <= slot_rs1_d;
      slot_rs2_q   <= slot_rs2_d;
      pending_q    <= pending_d;
    end
  end

  // While stalled the held sources are re-read; they are never pending, so data stays stable.
  assign rd_addr1_op   = accept ? dec_rs1 : slot_rs1_q;
  assign rd_addr2_op   = accept ? dec_rs2 : slot_rs2_q;
  assign ex_valid_op   = slot_valid_q;
  assign ex_instr_op   = slot_instr_q;
  assign ex_rd_op      = slot_rd_q;
  assign sb_pending_op = pending_q;

endmodule
